// File: rtl/vscale_fetch_queue.sv
// Instruction-fetch front end: issues sequential fetches into a DEPTH-entry
// prefetch queue and presents {pc, inst, badmem} to DX, flushing on redirect.
module vscale_fetch_queue #(
  parameter int                  XPR_LEN  = 32,
  parameter int                  DEPTH    = 4,
  parameter logic [XPR_LEN-1:0]  RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         imem_req,
  output logic [XPR_LEN-1:0]           imem_addr,
  input  logic                         imem_wait,
  input  logic [XPR_LEN-1:0]           imem_rdata,
  input  logic                         imem_badmem_e,
  input  logic                         redirect_valid,
  input  logic [XPR_LEN-1:0]           redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XPR_LEN-1:0]           out_pc,
  output logic [XPR_LEN-1:0]           out_inst,
  output logic                         out_badmem,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH+1);
  localparam int CW1 = CW + 1;
  localparam logic [XPR_LEN-1:0] RV_NOP = XPR_LEN'(32'h0000_0013);

  logic [XPR_LEN-1:0] pc_mem   [DEPTH];
  logic [XPR_LEN-1:0] inst_mem [DEPTH];
  logic               bad_mem  [DEPTH];

  logic [XPR_LEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XPR_LEN-1:0] inflight_pc_q, inflight_pc_d;
  logic               inflight_q, inflight_d;
  logic               halted_q, halted_d;
  logic [PW-1:0]      head_q, head_d;
  logic [PW-1:0]      tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;

  logic               deq, enq, accept;
  logic [CW-1:0]      count_eff;
  logic               inflight_eff, halted_eff;
  logic [CW1-1:0]     level, limit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake: the head entry transfers to DX on a cycle where out_valid and
  // out_ready are both high and no redirect is present; otherwise it is held.
  assign out_valid  = (count_q != '0);
  assign out_pc     = out_valid ? pc_mem[head_q]   : '0;
  assign out_inst   = out_valid ? inst_mem[head_q] : RV_NOP;
  assign out_badmem = out_valid ? bad_mem[head_q]  : 1'b0;
  assign occupancy  = count_q;

  assign deq = out_valid & out_ready & ~redirect_valid;
  assign enq = inflight_q & ~redirect_valid & ~reset;

  // A redirect discards everything, so the issue check sees an empty machine.
  assign count_eff    = redirect_valid ? '0   : count_q;
  assign inflight_eff = redirect_valid ? 1'b0 : inflight_q;
  assign halted_eff   = redirect_valid ? 1'b0 : halted_q;

  assign level     = CW1'(count_eff) + CW1'(inflight_eff);
  assign limit     = CW1'(DEPTH) + CW1'(deq);
  assign imem_addr = redirect_valid ? redirect_pc : fetch_pc_q;
  assign imem_req  = ~reset & ~halted_eff & (level < limit);
  assign accept    = imem_req & ~imem_wait;

  always_comb begin
    fetch_pc_d    = accept ? imem_addr + XPR_LEN'(4) : imem_addr;
    inflight_d    = accept;
    inflight_pc_d = accept ? imem_addr : inflight_pc_q;
    tail_d        = enq ? ptr_inc(tail_q) : tail_q;
    head_d        = deq ? ptr_inc(head_q) : head_q;
    halted_d      = halted_q | (enq & imem_badmem_e);
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (redirect_valid) begin
      head_d   = tail_q;
      count_d  = '0;
      halted_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      halted_q      <= 1'b0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      halted_q      <= halted_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[tail_q]   <= inflight_pc_q;
      inst_mem[tail_q] <= imem_rdata;
      bad_mem[tail_q]  <= imem_badmem_e;
    end
  end

endmodule

// File: tb/tb_vscale_fetch_queue.sv
// Bench for vscale_fetch_queue: three depths (4, 3, 1) driven in lockstep and
// compared every cycle against a queue-level reference model.
module tb_vscale_fetch_queue;

  localparam int N = 3;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        bad;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, imem_wait, imem_badmem_e, redirect_valid, out_ready;
  logic [31:0] redirect_pc;
  logic        imem_req   [N];
  logic [31:0] imem_addr  [N];
  logic [31:0] imem_rdata [N];
  logic [31:0] resp_addr  [N];
  logic        out_valid  [N];
  logic [31:0] out_pc     [N];
  logic [31:0] out_inst   [N];
  logic        out_badmem [N];
  logic [2:0]  occ0;
  logic [1:0]  occ1;
  logic [0:0]  occ2;

  vscale_fetch_queue #(.XPR_LEN(32), .DEPTH(4), .RESET_PC(32'h0)) u0 (
    .clk(clk), .reset(reset), .imem_req(imem_req[0]), .imem_addr(imem_addr[0]),
    .imem_wait(imem_wait), .imem_rdata(imem_rdata[0]), .imem_badmem_e(imem_badmem_e),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_pc(out_pc[0]),
    .out_inst(out_inst[0]), .out_badmem(out_badmem[0]), .occupancy(occ0));

  vscale_fetch_queue #(.XPR_LEN(32), .DEPTH(3), .RESET_PC(32'h0)) u1 (
    .clk(clk), .reset(reset), .imem_req(imem_req[1]), .imem_addr(imem_addr[1]),
    .imem_wait(imem_wait), .imem_rdata(imem_rdata[1]), .imem_badmem_e(imem_badmem_e),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_pc(out_pc[1]),
    .out_inst(out_inst[1]), .out_badmem(out_badmem[1]), .occupancy(occ1));

  vscale_fetch_queue #(.XPR_LEN(32), .DEPTH(1), .RESET_PC(32'h0)) u2 (
    .clk(clk), .reset(reset), .imem_req(imem_req[2]), .imem_addr(imem_addr[2]),
    .imem_wait(imem_wait), .imem_rdata(imem_rdata[2]), .imem_badmem_e(imem_badmem_e),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid[2]), .out_ready(out_ready), .out_pc(out_pc[2]),
    .out_inst(out_inst[2]), .out_badmem(out_badmem[2]), .occupancy(occ2));

  // Instruction memory: the word for an address is a fixed scramble of it.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) resp_addr[k] <= imem_addr[k];
  end

  always_comb begin
    for (int k = 0; k < N; k++) imem_rdata[k] = mem_word(resp_addr[k]);
  end

  // ---------------- reference model ----------------
  logic [31:0] m_fpc  [N];
  logic [31:0] m_ipc  [N];
  logic        m_infl [N];
  logic        m_halt [N];
  ent_t        m_q    [N][8];
  int          m_cnt  [N];
  bit          m_init = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  bit          sb_on = 1'b0;

  function automatic int depth_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 3 : 1;
  endfunction

  function automatic int get_occ(input int k);
    return (k == 0) ? int'(occ0) : (k == 1) ? int'(occ1) : int'(occ2);
  endfunction

  function automatic logic m_req(input int k);
    int ce, ie, dq;
    bit he;
    if (reset) return 1'b0;
    ce = redirect_valid ? 0 : m_cnt[k];
    ie = redirect_valid ? 0 : int'(m_infl[k]);
    he = redirect_valid ? 1'b0 : m_halt[k];
    dq = (m_cnt[k] > 0 && out_ready && !redirect_valid) ? 1 : 0;
    return !he && (ce + ie - dq < depth_of(k));
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < N; k++) begin
      logic er;
      er = m_req(k);
      check_eq($sformatf("req%0d", k), 32'(imem_req[k]), 32'(er));
      if (m_init) begin
        if (er) check_eq($sformatf("addr%0d", k), imem_addr[k],
                         redirect_valid ? redirect_pc : m_fpc[k]);
        check_eq($sformatf("valid%0d", k), 32'(out_valid[k]), 32'(m_cnt[k] > 0));
        check_eq($sformatf("occ%0d", k), 32'(get_occ(k)), 32'(m_cnt[k]));
        check_eq($sformatf("pc%0d", k), out_pc[k], (m_cnt[k] > 0) ? m_q[k][0].pc : 32'h0);
        check_eq($sformatf("inst%0d", k), out_inst[k], (m_cnt[k] > 0) ? m_q[k][0].inst : NOP);
        check_eq($sformatf("bad%0d", k), 32'(out_badmem[k]),
                 (m_cnt[k] > 0) ? 32'(m_q[k][0].bad) : 32'h0);
      end
    end
    if (sb_on && m_cnt[0] > 0 && out_ready && !redirect_valid && exp_q.size() > 0)
      check_eq("sb_pc", out_pc[0], exp_q.pop_front());
  endtask

  task automatic model_step();
    for (int k = 0; k < N; k++) begin
      logic        acc;
      logic [31:0] a;
      bit          dq;
      acc = m_req(k) && !imem_wait;
      a   = redirect_valid ? redirect_pc : m_fpc[k];
      dq  = m_cnt[k] > 0 && out_ready && !redirect_valid;
      if (reset) begin
        m_fpc[k]  = 32'h0;
        m_ipc[k]  = 32'h0;
        m_infl[k] = 1'b0;
        m_halt[k] = 1'b0;
        m_cnt[k]  = 0;
      end else begin
        if (redirect_valid) begin
          m_cnt[k]  = 0;
          m_halt[k] = 1'b0;
        end else begin
          if (dq) begin
            for (int i = 0; i < 7; i++) m_q[k][i] = m_q[k][i+1];
            m_cnt[k]--;
          end
          if (m_infl[k]) begin
            m_q[k][m_cnt[k]] = {m_ipc[k], mem_word(m_ipc[k]), imem_badmem_e};
            m_cnt[k]++;
            if (imem_badmem_e) m_halt[k] = 1'b1;
          end
        end
        m_infl[k] = acc;
        if (acc) m_ipc[k] = a;
        m_fpc[k] = acc ? a + 32'd4 : a;
      end
    end
    if (reset) m_init = 1'b1;
  endtask

  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    cycle();
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  int max_occ;

  initial begin
    reset = 1'b1; imem_wait = 1'b0; imem_badmem_e = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    @(negedge clk);

    // Streaming from reset: one instruction per cycle, shallow occupancy.
    do_reset();
    max_occ = 0;
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (c >= 3) begin
        check_eq("seq_valid", 32'(out_valid[0]), 32'h1);
        check_eq("seq_pc", out_pc[0], 32'((c - 3) * 4));
      end
      if (get_occ(0) > max_occ) max_occ = get_occ(0);
      cycle();
    end
    check_eq("occ_max_le2", 32'(max_occ <= 2), 32'h1);

    // Backpressure fills the queue, then release delivers in order.
    do_reset();
    out_ready = 1'b0;
    run(10);
    #1;
    check_eq("stall_occ", 32'(get_occ(0)), 32'd4);
    check_eq("stall_req", 32'(imem_req[0]), 32'h0);
    check_eq("stall_head", out_pc[0], 32'h0);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    sb_on = 1'b1;
    out_ready = 1'b1;
    run(14);
    sb_on = 1'b0;
    check_eq("sb_drained", 32'(exp_q.size()), 32'h0);

    // Redirect with three entries queued and one in flight.
    do_reset();
    out_ready = 1'b0;
    run(4);
    #1;
    check_eq("redir_pre_occ", 32'(get_occ(0)), 32'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    cycle();
    redirect_valid = 1'b0; out_ready = 1'b1;
    #1;
    check_eq("redir_occ0", 32'(get_occ(0)), 32'h0);
    cycle();
    #1;
    check_eq("redir_pc0", out_pc[0], 32'h100);
    cycle();
    #1;
    check_eq("redir_pc1", out_pc[0], 32'h104);
    cycle();

    // Fault on the response for 0x8 halts fetching until a redirect.
    do_reset();
    out_ready = 1'b1;
    run(3);
    imem_badmem_e = 1'b1;
    cycle();
    imem_badmem_e = 1'b0;
    #1;
    check_eq("fault_pc", out_pc[0], 32'h8);
    check_eq("fault_flag", 32'(out_badmem[0]), 32'h1);
    run(3);
    #1;
    check_eq("fault_halt_req", 32'(imem_req[0]), 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    #1;
    check_eq("fault_resume_pc", out_pc[0], 32'h200);
    run(4);

    // Memory wait mid-stream.
    imem_wait = 1'b1;
    run(3);
    imem_wait = 1'b0;
    run(8);

    // Address wrap at the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cycle();
    redirect_valid = 1'b0;
    #1;
    check_eq("wrap_addr_fffc", imem_addr[0], 32'hFFFF_FFFC);
    cycle();
    #1;
    check_eq("wrap_addr_0", imem_addr[0], 32'h0);
    run(6);

    // Reset in the middle of a stream.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
    check_eq("midreset_valid", 32'(out_valid[0]), 32'h0);
    check_eq("midreset_occ", 32'(get_occ(0)), 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      reset          = ($urandom_range(0, 149) == 0);
      redirect_valid = ($urandom_range(0, 14) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2)
                                                   : (32'($urandom_range(0, 1023)) << 2);
      out_ready      = ($urandom_range(0, 9) < 7);
      imem_wait      = ($urandom_range(0, 3) == 0);
      imem_badmem_e  = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vscale_fetch_queue.md
# vscale_fetch_queue

Parametrised instruction-fetch front end for the vscale pipeline. It replaces the single PC_IF/inst_DX register pair with a DEPTH-entry prefetch queue between instruction memory and the DX stage. It issues sequential fetches ahead of decode, tags memory faults per entry, and flushes on redirect (branch, jump, exception or handler entry). The DX stage consumes {pc, inst, badmem} through a valid/ready handshake.

## Interface
- XPR_LEN, 32: PC and instruction width.
- DEPTH, 4: queue entries; any value ≥1, not required to be a power of two.
- RESET_PC, 32'h0: first fetch address after reset.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- imem_req  output  1  fetch request this cycle.
- imem_addr  output  XPR_LEN  fetch address.
- imem_wait  input  1  memory not accepting; request in this cycle is not taken.
- imem_rdata  input  XPR_LEN  instruction, valid the cycle after acceptance.
- imem_badmem_e  input  1  fault flag, same timing as imem_rdata.
- redirect_valid  input  1  flush and restart fetch.
- redirect_pc  input  XPR_LEN  new fetch address.
- out_valid  output  1  queue head valid.
- out_ready  input  1  DX accepts head.
- out_pc  output  XPR_LEN  head PC.
- out_inst  output  XPR_LEN  head instruction.
- out_badmem  output  1  head fetch faulted.
- occupancy  output  $clog2(DEPTH+1)  valid entries.

## Operation
- State:
  - fetch_pc register.
  - Circular buffer of DEPTH entries {pc, inst, badmem} with head/tail pointers wrapping DEPTH-1→0.
  - count.
  - inflight bit with inflight_pc.
  - halted bit.
- imem_addr = redirect_valid ? redirect_pc : fetch_pc (combinational).
- deq = out_valid & out_ready & ~redirect_valid.
- imem_req = ~reset & ~halted_eff & (count_eff + inflight_eff - deq < DEPTH).
  - On a redirect cycle, count_eff = 0, inflight_eff = 0 and halted_eff = 0.
  - Otherwise these are the registered values.
- Request accepted when imem_req & ~imem_wait:
  - inflight ← 1, inflight_pc ← imem_addr.
  - fetch_pc ← imem_addr + 4, modulo 2^XPR_LEN.
- No acceptance → inflight ← 0 and fetch_pc holds (or takes redirect_pc on redirect).
- Response handling, cycle with inflight=1 and no redirect:
  - Enqueue {inflight_pc, imem_rdata, imem_badmem_e} at tail.
  - Space is guaranteed by the issue rule.
- Response with imem_badmem_e=1 is enqueued and sets halted. No further requests until redirect.
- redirect_valid, which has priority over all other events:
  - count ← 0 and head = tail.
  - Any response arriving this cycle is discarded; halted ← 0.
  - Handshake on out_* in this cycle is a no-op; DX treats the head as killed.
  - The request to redirect_pc may issue this same cycle.
- Simultaneous enqueue and dequeue: count unchanged; both pointers advance.
- Empty queue outputs:
  - out_valid=0, out_inst=32'h00000013 (RV_NOP), out_pc=0, out_badmem=0.
- Non-empty queue: out_* are the head entry contents.
- The head entry is held stable while out_valid & ~out_ready.

## Timing
- Reset (cycle with reset=1):
  - fetch_pc←RESET_PC; count, inflight, halted, head and tail ← 0.
  - Outputs: imem_req=0, out_valid=0, occupancy=0.
- First cycle after reset: request RESET_PC. Its response arrives the next cycle, and out_valid=1 the cycle after that.
- Fetch-to-out_valid latency: 2 cycles (accept cycle t, response t+1, head visible t+2).
- Redirect-to-out_valid: 2 cycles when imem_wait=0.
- Sustained throughput: 1 instruction/cycle for DEPTH≥2 with out_ready=1 and imem_wait=0. Same-cycle dequeue credit makes this possible.
- DEPTH=1: 1 instruction per 2 cycles.
- reset mid-operation overrides redirect, responses and handshakes; the in-flight response is dropped.
- occupancy is registered; it never exceeds DEPTH.

## Test plan
- Reset then out_ready=1, imem_wait=0, DEPTH=4:
  - out_pc 0,4,8,… on consecutive cycles from cycle 2.
  - One dequeue per cycle; occupancy never exceeds 2.
- out_ready=0 for 10 cycles:
  - occupancy reaches 4 and imem_req drops.
  - Head stays pc=0.
  - Release → pcs 0..0x1C delivered in order with no gaps or duplicates.
- Redirect to 0x100 with 3 entries queued and one in flight:
  - occupancy=0 next cycle; in-flight data not enqueued.
  - out_pc=0x100 two cycles later, then 0x104.
- imem_badmem_e=1 on the response for 0x8:
  - Entry 0x8 delivered with out_badmem=1; no requests after it.
  - Redirect to 0x200 resumes fetching.
- imem_wait=1 for 3 cycles mid-stream: imem_addr held, no duplicate or skipped PCs.
- Wrap-around and boundaries:
  - fetch_pc=0xFFFFFFFC → next is 0x0.
  - DEPTH=3 pointer wrap over 20 instructions is in order.
  - reset asserted mid-stream → out_valid=0 and occupancy=0 next cycle.
